// File: rtl/brush_draw_ctrl.sv
// Brush drawing sequencer: queues decoded SPI commands and expands each brush
// stroke into a clipped square of frame-buffer pixel writes, gated by the arbiter grant.
module brush_draw_ctrl #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmdValid,
    input  logic              brushUpdate,
    input  logic              updateConfig,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [2:0]        newColorUpdate,
    input  logic              fbGrant,
    output logic              fbWe,
    output logic [ADDR_W-1:0] fbAddr,
    output logic [2:0]        fbData,
    output logic              cmdDrop,
    output logic              busy
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PAINT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Command FIFO storage, entry = {is_config, x, y, color}
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [ENTRY_W-1:0] head_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic push_req, push_ok, pop;

    logic       h_cfg;
    logic [7:0] h_x, h_y;
    logic [2:0] h_col;

    logic [2:0]        color_reg, draw_color_reg;
    logic [1:0]        radius_reg;
    logic [7:0]        cx_reg, cy_reg;
    logic signed [3:0] stroke_r_reg, dx_reg, dy_reg;

    logic [9:0]        px, py;
    logic              in_bounds, advance, last_pix;
    logic [ADDR_W-1:0] pix_addr;

    assign push_req = cmdValid & (updateConfig | brushUpdate);
    assign push_ok  = push_req && (count_reg < CNT_W'(DEPTH));
    assign pop      = (state_reg == IDLE) && (count_reg != '0);

    assign h_cfg = head_reg[19];
    assign h_x   = head_reg[18:11];
    assign h_y   = head_reg[10:3];
    assign h_col = head_reg[2:0];

    // RAM write and registered head read; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= {updateConfig, x, y, newColorUpdate};
        end
        if (pop) begin
            head_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            cmdDrop    <= 1'b0;
        end else begin
            cmdDrop <= push_req & ~push_ok;
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Pixel position relative to the latched stroke centre
    assign px = {2'b00, cx_reg} + {{6{dx_reg[3]}}, dx_reg};
    assign py = {2'b00, cy_reg} + {{6{dy_reg[3]}}, dy_reg};

    assign in_bounds = !px[9] && !py[9] && (px < 10'(WIDTH)) && (py < 10'(HEIGHT));
    assign advance   = !in_bounds | fbGrant;
    assign last_pix  = (dx_reg == stroke_r_reg) && (dy_reg == stroke_r_reg);
    assign pix_addr  = ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = LOAD;
            LOAD:    state_next = h_cfg ? IDLE : PAINT;
            PAINT:   if (advance && last_pix) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fbWe   = 1'b0;
        fbAddr = '0;
        fbData = '0;
        if (state_reg == PAINT) begin
            fbData = draw_color_reg;
            if (in_bounds) begin
                fbAddr = pix_addr;
                fbWe   = fbGrant;
            end
        end
    end

    assign busy = (count_reg != '0) || (state_reg != IDLE);

    // Stroke datapath: config registers plus the per-stroke scan counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_reg      <= '0;
            radius_reg     <= '0;
            draw_color_reg <= '0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            stroke_r_reg   <= '0;
            dx_reg         <= '0;
            dy_reg         <= '0;
        end else begin
            if (state_reg == LOAD) begin
                if (h_cfg) begin
                    color_reg  <= h_col;
                    radius_reg <= h_x[1:0];
                end else begin
                    cx_reg         <= h_x;
                    cy_reg         <= h_y;
                    draw_color_reg <= color_reg;
                    stroke_r_reg   <= $signed({2'b00, radius_reg});
                    dx_reg         <= -$signed({2'b00, radius_reg});
                    dy_reg         <= -$signed({2'b00, radius_reg});
                end
            end else if (state_reg == PAINT && advance) begin
                if (dx_reg == stroke_r_reg) begin
                    dx_reg <= -stroke_r_reg;
                    dy_reg <= dy_reg + 4'sd1;
                end else begin
                    dx_reg <= dx_reg + 4'sd1;
                end
            end
        end
    end

endmodule
